// File: rtl/inst_issue_queue_pkg.sv
// rtl/inst_issue_queue_pkg.sv - shared types and constants for the instruction issue queue
package inst_issue_queue_pkg;

   localparam logic       ISSUE_SINGLE = 1'b0;
   localparam logic       ISSUE_DUAL   = 1'b1;
   localparam logic [4:0] NOP_REG_ADDR = 5'd0;

   localparam logic [5:0] OP_SPECIAL  = 6'h00;
   localparam logic [5:0] OP_REGIMM   = 6'h01;
   localparam logic [5:0] OP_J        = 6'h02;
   localparam logic [5:0] OP_JAL      = 6'h03;
   localparam logic [5:0] OP_COP0     = 6'h10;
   localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } entry_t;

   typedef struct packed {
      logic [4:0] waddr;
      logic       we;
      logic [4:0] raddr1;
      logic       re1;
      logic [4:0] raddr2;
      logic       re2;
      logic       branch;
      logic       mem;
      logic       hilo;
      logic       priv;
   } pd_t;

endpackage

// File: rtl/inst_issue_queue_predecode.sv
// rtl/inst_issue_queue_predecode.sv - combinational pre-decode of one queued instruction
// Extracts register usage and class bits needed for the pairing decision.
module inst_issue_queue_predecode
   import inst_issue_queue_pkg::*;
(
   input  logic [31:0] inst,
   output pd_t         pd_o
);

   logic [5:0] op, funct;
   logic [4:0] rs, rt, rd;
   logic       unused_shamt;

   assign op           = inst[31:26];
   assign rs           = inst[25:21];
   assign rt           = inst[20:16];
   assign rd           = inst[15:11];
   assign funct        = inst[5:0];
   assign unused_shamt = ^inst[10:6];

   always_comb begin
      pd_o        = '0;
      pd_o.raddr1 = rs;
      pd_o.raddr2 = rt;
      pd_o.re1    = 1'b1;
      case (op)
         OP_SPECIAL: begin
            pd_o.re2   = 1'b1;
            pd_o.we    = 1'b1;
            pd_o.waddr = rd;
            case (funct)
               6'h08: begin pd_o.branch = 1'b1; pd_o.we = 1'b0; end
               6'h09: pd_o.branch = 1'b1;
               6'h0C, 6'h0D: begin pd_o.priv = 1'b1; pd_o.we = 1'b0; end
               6'h10, 6'h12: pd_o.hilo = 1'b1;
               6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: begin
                  pd_o.hilo = 1'b1;
                  pd_o.we   = 1'b0;
               end
               default: ;
            endcase
         end
         // Link variants (BGEZAL/BLTZAL) write $31
         OP_REGIMM: begin
            pd_o.branch = 1'b1;
            pd_o.we     = rt[4];
            pd_o.waddr  = 5'd31;
         end
         OP_J: begin pd_o.branch = 1'b1; pd_o.re1 = 1'b0; end
         OP_JAL: begin
            pd_o.branch = 1'b1;
            pd_o.re1    = 1'b0;
            pd_o.we     = 1'b1;
            pd_o.waddr  = 5'd31;
         end
         6'h04, 6'h05: begin pd_o.branch = 1'b1; pd_o.re2 = 1'b1; end
         6'h06, 6'h07: pd_o.branch = 1'b1;
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
            pd_o.we    = 1'b1;
            pd_o.waddr = rt;
         end
         OP_COP0: begin
            pd_o.priv  = 1'b1;
            pd_o.re1   = 1'b0;
            pd_o.we    = (rs == 5'd0);
            pd_o.waddr = rt;
            pd_o.re2   = (rs == 5'd4);
         end
         OP_SPECIAL2: begin
            pd_o.hilo  = 1'b1;
            pd_o.re2   = 1'b1;
            pd_o.we    = (funct == 6'h02);
            pd_o.waddr = rd;
         end
         default: begin
            if (op[5:4] == 2'b10) begin
               pd_o.mem   = 1'b1;
               pd_o.we    = !op[3];
               pd_o.waddr = rt;
               pd_o.re2   = op[3];
            end
         end
      endcase
   end

endmodule

// File: rtl/inst_issue_queue.sv
// rtl/inst_issue_queue.sv - instruction buffer and one/two-wide issue pairing between fetch and decode
// Circular buffer with combinational head outputs; pairing legality is decided from pre-decoded head entries.
module inst_issue_queue
   import inst_issue_queue_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int FETCH_W = 2,
   parameter int ISSUE_W = 2,
   localparam int CNT_W  = $clog2(DEPTH + 1),
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 stall,
   input  logic [FETCH_W-1:0]   push_valid_i,
   input  logic [FETCH_W*32-1:0] push_inst_i,
   input  logic [FETCH_W*32-1:0] push_pc_i,
   output logic                 push_ready_o,
   output logic [31:0]          inst1_o,
   output logic [31:0]          pc1_o,
   output logic [31:0]          inst2_o,
   output logic [31:0]          pc2_o,
   output logic                 valid1_o,
   output logic                 valid2_o,
   output logic                 issue_o,
   output logic                 is_in_delayslot1_o,
   output logic                 is_in_delayslot2_o,
   output logic [CNT_W-1:0]     count_o
);

   entry_t            mem_q [DEPTH];
   entry_t            mem_d [DEPTH];
   logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d, push_cnt, pop_cnt;
   logic              ds_pending_q, ds_pending_d;
   logic              push_en, pop_en, pair_ok, raw;
   entry_t            e1, e2;
   pd_t               pd1, pd2;
   logic              unused_pd;

   assign e1 = mem_q[head_q];
   assign e2 = mem_q[head_q + PTR_W'(1)];

   inst_issue_queue_predecode u_pd1 (.inst(e1.inst), .pd_o(pd1));
   inst_issue_queue_predecode u_pd2 (.inst(e2.inst), .pd_o(pd2));

   assign unused_pd = ^{pd1.raddr1, pd1.re1, pd1.raddr2, pd1.re2, pd2.waddr, pd2.we};

   // Writing $0 never creates a dependency
   assign raw = pd1.we && (pd1.waddr != NOP_REG_ADDR) &&
                ((pd2.re1 && (pd2.raddr1 == pd1.waddr)) ||
                 (pd2.re2 && (pd2.raddr2 == pd1.waddr)));

   // A branch sitting in a pending delay slot must issue alone so its own slot re-arms cleanly
   assign pair_ok = (ISSUE_W == 2) && (count_q >= CNT_W'(2)) &&
                    !pd2.branch && !pd1.priv && !pd2.priv &&
                    !(pd1.mem && pd2.mem) && !(pd1.hilo && pd2.hilo) &&
                    !raw && !(ds_pending_q && pd1.branch);

   assign valid1_o           = (count_q != '0);
   assign valid2_o           = pair_ok;
   assign inst1_o            = valid1_o ? e1.inst : 32'h0;
   assign pc1_o              = valid1_o ? e1.pc   : 32'h0;
   assign inst2_o            = valid2_o ? e2.inst : 32'h0;
   assign pc2_o              = valid2_o ? e2.pc   : 32'h0;
   assign issue_o            = valid2_o ? ISSUE_DUAL : ISSUE_SINGLE;
   assign is_in_delayslot1_o = valid1_o && ds_pending_q;
   assign is_in_delayslot2_o = valid2_o && pd1.branch;
   assign count_o            = count_q;
   assign push_ready_o       = (count_q <= CNT_W'(DEPTH - FETCH_W));

   assign push_en = push_ready_o && !flush;
   assign pop_en  = !stall && !flush;

   always_comb begin
      mem_d        = mem_q;
      head_d       = head_q;
      ds_pending_d = ds_pending_q;
      push_cnt     = '0;
      pop_cnt      = '0;
      if (push_en) begin
         for (int k = 0; k < FETCH_W; k++) begin
            if (push_valid_i[k]) begin
               mem_d[tail_q + push_cnt[PTR_W-1:0]] = '{inst: push_inst_i[32*k +: 32],
                                                      pc:   push_pc_i[32*k +: 32]};
               push_cnt = push_cnt + CNT_W'(1);
            end
         end
      end
      tail_d = tail_q + push_cnt[PTR_W-1:0];
      if (pop_en) begin
         pop_cnt = CNT_W'(valid1_o) + CNT_W'(valid2_o);
         head_d  = head_q + pop_cnt[PTR_W-1:0];
         if (valid1_o) ds_pending_d = !valid2_o && pd1.branch;
      end
      count_d = count_q + push_cnt - pop_cnt;
      if (flush) begin
         head_d       = tail_q;
         tail_d       = tail_q;
         count_d      = '0;
         ds_pending_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q        <= '{default: '0};
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         ds_pending_q <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         ds_pending_q <= ds_pending_d;
      end
   end

endmodule

// File: tb/tb_inst_issue_queue.sv
// tb/tb_inst_issue_queue.sv - scoreboard bench for inst_issue_queue
module tb_inst_issue_queue;

   localparam int DEPTH = 16;
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef logic [131:0] rec_t;

   logic              clk = 1'b0;
   logic              rst, flush, stall;
   logic [1:0]        push_valid_i;
   logic [63:0]       push_inst_i, push_pc_i;
   logic              push_ready_o, valid1_o, valid2_o, issue_o;
   logic              is_in_delayslot1_o, is_in_delayslot2_o;
   logic [31:0]       inst1_o, pc1_o, inst2_o, pc2_o;
   logic [CNT_W-1:0]  count_o;

   int   checks = 0;
   int   failures = 0;
   rec_t sb[$];
   rec_t mon_act, mon_exp;

   inst_issue_queue #(.DEPTH(DEPTH), .FETCH_W(2), .ISSUE_W(2)) dut (
      .clk(clk), .rst(rst), .flush(flush), .stall(stall),
      .push_valid_i(push_valid_i), .push_inst_i(push_inst_i), .push_pc_i(push_pc_i),
      .push_ready_o(push_ready_o),
      .inst1_o(inst1_o), .pc1_o(pc1_o), .inst2_o(inst2_o), .pc2_o(pc2_o),
      .valid1_o(valid1_o), .valid2_o(valid2_o), .issue_o(issue_o),
      .is_in_delayslot1_o(is_in_delayslot1_o), .is_in_delayslot2_o(is_in_delayslot2_o),
      .count_o(count_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] addu(input int rd, input int rs, input int rt);
      logic [4:0] d, s, t;
      d = rd[4:0]; s = rs[4:0]; t = rt[4:0];
      return {6'h00, s, t, d, 5'h00, 6'h21};
   endfunction

   function automatic logic [31:0] beq(input int rs, input int rt, input int off);
      logic [4:0] s, t;
      logic [15:0] o;
      s = rs[4:0]; t = rt[4:0]; o = off[15:0];
      return {6'h04, s, t, o};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic exp1(input logic [31:0] i, input logic [31:0] p, input logic ds);
      sb.push_back({1'b0, 1'b0, ds, 1'b0, i, p, 32'h0, 32'h0});
   endtask

   task automatic exp2(input logic [31:0] i1, input logic [31:0] p1,
                       input logic [31:0] i2, input logic [31:0] p2, input logic ds2);
      sb.push_back({1'b1, 1'b1, 1'b0, ds2, i1, p1, i2, p2});
   endtask

   task automatic push(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1);
      push_valid_i = v;
      push_inst_i  = {i1, i0};
      push_pc_i    = {p1, p0};
      @(posedge clk); #1;
      push_valid_i = '0;
      push_inst_i  = '0;
      push_pc_i    = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (count_o != 0 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 64'(count_o), 64'd0);
      check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
   endtask

   // Issues are consumed on the next rising edge when neither stalled nor flushed
   always @(negedge clk) begin
      if (rst && !stall && !flush && valid1_o) begin
         mon_act = {valid2_o, issue_o, is_in_delayslot1_o, is_in_delayslot2_o,
                    inst1_o, pc1_o, inst2_o, pc2_o};
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL issue_unexpected actual=%h expected=none", mon_act);
         end else begin
            mon_exp = sb.pop_front();
            if (mon_act !== mon_exp) begin
               failures++;
               $display("FAIL issue actual=%h expected=%h", mon_act, mon_exp);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; flush = 1'b0; stall = 1'b0;
      push_valid_i = '0; push_inst_i = '0; push_pc_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_count", 64'(count_o), 64'd0);
      check("rst_valid1", 64'(valid1_o), 64'd0);
      check("rst_ready", 64'(push_ready_o), 64'd1);
      check("rst_issue", 64'(issue_o), 64'd0);
      rst = 1'b1;
      idle(1);

      // independent pair
      exp2(addu(1, 2, 3), 32'h100, addu(4, 5, 6), 32'h104, 1'b0);
      push(2'b11, addu(1, 2, 3), 32'h100, addu(4, 5, 6), 32'h104);
      check("indep_count2", 64'(count_o), 64'd2);
      check("indep_valid2", 64'(valid2_o), 64'd1);
      idle(1);
      check("indep_count0", 64'(count_o), 64'd0);

      // RAW forces two single issues
      exp1(addu(1, 2, 3), 32'h200, 1'b0);
      exp1(addu(4, 1, 6), 32'h204, 1'b0);
      push(2'b11, addu(1, 2, 3), 32'h200, addu(4, 1, 6), 32'h204);
      drain("raw_drain");

      // $0 destination carries no dependency
      exp2(addu(0, 2, 3), 32'h300, addu(4, 0, 6), 32'h304, 1'b0);
      push(2'b11, addu(0, 2, 3), 32'h300, addu(4, 0, 6), 32'h304);
      drain("zero_drain");

      // branch with delay slot in the same pair
      exp2(beq(1, 2, 4), 32'h400, addu(7, 8, 9), 32'h404, 1'b1);
      push(2'b11, beq(1, 2, 4), 32'h400, addu(7, 8, 9), 32'h404);
      drain("bpair_drain");

      // lone branch, delay slot arrives later
      exp1(beq(3, 4, 8), 32'h500, 1'b0);
      push(2'b01, beq(3, 4, 8), 32'h500, 32'h0, 32'h0);
      idle(3);
      exp1(addu(10, 11, 12), 32'h504, 1'b1);
      push(2'b01, addu(10, 11, 12), 32'h504, 32'h0, 32'h0);
      drain("blone_drain");

      // fill under stall, drop when full, drain across pointer wrap
      stall = 1'b1;
      for (int j = 0; j < 8; j++) begin
         exp2(addu(8 + 2*j, 1, 2), 32'h2000 + 32'(8*j), addu(9 + 2*j, 1, 2), 32'h2004 + 32'(8*j), 1'b0);
         push(2'b11, addu(8 + 2*j, 1, 2), 32'h2000 + 32'(8*j), addu(9 + 2*j, 1, 2), 32'h2004 + 32'(8*j));
      end
      check("full_count", 64'(count_o), 64'd16);
      check("full_ready", 64'(push_ready_o), 64'd0);
      push(2'b11, addu(30, 1, 2), 32'h3000, addu(31, 1, 2), 32'h3004);
      check("full_drop", 64'(count_o), 64'd16);
      stall = 1'b0;
      drain("full_drain");

      // flush with pending delay slot and a simultaneous push
      exp1(beq(5, 6, 4), 32'h600, 1'b0);
      push(2'b01, beq(5, 6, 4), 32'h600, 32'h0, 32'h0);
      idle(2);
      stall = 1'b1;
      push(2'b11, addu(13, 1, 2), 32'h608, addu(14, 1, 2), 32'h60c);
      flush = 1'b1;
      push(2'b11, addu(15, 1, 2), 32'h610, addu(16, 1, 2), 32'h614);
      flush = 1'b0;
      stall = 1'b0;
      check("flush_count", 64'(count_o), 64'd0);
      check("flush_valid1", 64'(valid1_o), 64'd0);
      exp1(addu(17, 1, 2), 32'h700, 1'b0);
      push(2'b01, addu(17, 1, 2), 32'h700, 32'h0, 32'h0);
      drain("flush_drain");

      // asynchronous reset mid-stream
      stall = 1'b1;
      push(2'b11, addu(18, 1, 2), 32'h800, addu(19, 1, 2), 32'h804);
      check("areset_pre_count", 64'(count_o), 64'd2);
      #2 rst = 1'b0;
      #1;
      check("areset_count", 64'(count_o), 64'd0);
      check("areset_valid1", 64'(valid1_o), 64'd0);
      check("areset_ready", 64'(push_ready_o), 64'd1);
      #3 rst = 1'b1;
      stall = 1'b0;
      idle(3);
      check("areset_post_count", 64'(count_o), 64'd0);
      check("sb_final_empty", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
